// File: rtl/regfile_wb_queue_pkg.sv
// Shared types and sizes for the register-file writeback queue.
package regfile_wb_queue_pkg;
  localparam int REG_ADDR_W = 4;
  localparam int DATA_W     = 16;
  localparam int WBQ_DEPTH  = 4;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0]     data;
  } wbq_entry_t;
endpackage

// File: rtl/regfile_wb_match.sv
// Scans in-flight writes (index 0 oldest) for one read address; newest match wins.
// Data selection exists only when REGFILE_WB_BYPASS_EN is defined.
module regfile_wb_match
  import regfile_wb_queue_pkg::*;
#(
  parameter int N = WBQ_DEPTH + 1
) (
  input  wbq_entry_t [N-1:0]      ents,
  input  logic [N-1:0]            vld,
  input  logic [REG_ADDR_W-1:0]   addr,
  output logic                    hit,
  output logic [DATA_W-1:0]       data
);

`ifndef REGFILE_WB_BYPASS_EN
  logic unused_data;
  always_comb begin
    unused_data = 1'b0;
    for (int i = 0; i < N; i++) begin
      unused_data = unused_data ^ (^ents[i].data);
    end
  end
`endif

  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int i = 0; i < N; i++) begin
      if (vld[i] && (ents[i].reg_addr == addr)) begin
        hit = 1'b1;
`ifdef REGFILE_WB_BYPASS_EN
        data = ents[i].data;
`endif
      end
    end
  end

endmodule

// File: rtl/regfile_wb_queue.sv
// In-order writeback queue driving the register file write port, with in-flight hazard reporting.
// Optional newest-data forwarding is compiled in with REGFILE_WB_BYPASS_EN.
module regfile_wb_queue
  import regfile_wb_queue_pkg::*;
#(
  parameter int DEPTH = WBQ_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_reg,
  input  logic [DATA_W-1:0]     wb_data,
  output logic                  wb_ready,
  input  logic                  wr_hold,
  output logic                  WriteReg,
  output logic [REG_ADDR_W-1:0] DstReg,
  output logic [DATA_W-1:0]     DstData,
  input  logic [REG_ADDR_W-1:0] SrcReg1,
  input  logic [REG_ADDR_W-1:0] SrcReg2,
  output logic                  pend1,
  output logic                  pend2,
  output logic [DATA_W-1:0]     fwd_data1,
  output logic [DATA_W-1:0]     fwd_data2
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int N  = DEPTH + 1;

  wbq_entry_t      mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;

  wbq_entry_t [N-1:0] ents;
  logic [N-1:0]       vld;

  assign wb_ready = (count != CW'(DEPTH));
  assign push     = wb_valid && wb_ready;
  assign pop      = (count != '0) && !wr_hold;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{reg_addr: wb_reg, data: wb_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      WriteReg <= 1'b0;
      DstReg   <= '0;
      DstData  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count    <= count + CW'(push) - CW'(pop);
      WriteReg <= pop;
      if (pop) begin
        DstReg  <= mem[rd_ptr].reg_addr;
        DstData <= mem[rd_ptr].data;
      end
    end
  end

  // Age order: output register first, then queue from head to tail.
  always_comb begin
    ents[0] = '{reg_addr: DstReg, data: DstData};
    vld[0]  = WriteReg;
    for (int k = 0; k < DEPTH; k++) begin
      ents[k+1] = mem[rd_ptr + AW'(k)];
      vld[k+1]  = (CW'(k) < count);
    end
  end

  regfile_wb_match #(.N(N)) u_match1 (
    .ents (ents),
    .vld  (vld),
    .addr (SrcReg1),
    .hit  (pend1),
    .data (fwd_data1)
  );

  regfile_wb_match #(.N(N)) u_match2 (
    .ents (ents),
    .vld  (vld),
    .addr (SrcReg2),
    .hit  (pend2),
    .data (fwd_data2)
  );

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed self-checking bench for regfile_wb_queue (DEPTH=4).
module tb_regfile_wb_queue;
  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic [3:0]  wb_reg;
  logic [15:0] wb_data;
  logic        wb_ready;
  logic        wr_hold;
  logic        WriteReg;
  logic [3:0]  DstReg;
  logic [15:0] DstData;
  logic [3:0]  SrcReg1;
  logic [3:0]  SrcReg2;
  logic        pend1;
  logic        pend2;
  logic [15:0] fwd_data1;
  logic [15:0] fwd_data2;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  regfile_wb_queue #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .wb_valid  (wb_valid),
    .wb_reg    (wb_reg),
    .wb_data   (wb_data),
    .wb_ready  (wb_ready),
    .wr_hold   (wr_hold),
    .WriteReg  (WriteReg),
    .DstReg    (DstReg),
    .DstData   (DstData),
    .SrcReg1   (SrcReg1),
    .SrcReg2   (SrcReg2),
    .pend1     (pend1),
    .pend2     (pend2),
    .fwd_data1 (fwd_data1),
    .fwd_data2 (fwd_data2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge (start of the next cycle).
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid_cycle();
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] exp_fwd;
    rst = 1'b1; wb_valid = 1'b0; wb_reg = '0; wb_data = '0;
    wr_hold = 1'b0; SrcReg1 = '0; SrcReg2 = '0;
    next_cycle();
    next_cycle();
    rst = 1'b0;

    // Reset then idle
    mid_cycle();
    chk("rst_writereg", 32'(WriteReg), 32'd0);
    chk("rst_dstreg", 32'(DstReg), 32'd0);
    chk("rst_dstdata", 32'(DstData), 32'd0);
    chk("rst_ready", 32'(wb_ready), 32'd1);
    chk("rst_pend1", 32'(pend1), 32'd0);
    chk("rst_pend2", 32'(pend2), 32'd0);
    chk("rst_fwd1", 32'(fwd_data1), 32'd0);
    chk("rst_fwd2", 32'(fwd_data2), 32'd0);

    // Single write R5=0x1234 in cycle 1
    next_cycle();
    SrcReg1 = 4'd5; wb_valid = 1'b1; wb_reg = 4'd5; wb_data = 16'h1234;
    mid_cycle();
    chk("single_c1_pend1", 32'(pend1), 32'd0);
    chk("single_c1_we", 32'(WriteReg), 32'd0);
    next_cycle();
    wb_valid = 1'b0;
    mid_cycle();
    chk("single_c2_we", 32'(WriteReg), 32'd0);
    chk("single_c2_pend1", 32'(pend1), 32'd1);
`ifdef REGFILE_WB_BYPASS_EN
    exp_fwd = 16'h1234;
`else
    exp_fwd = 16'h0000;
`endif
    chk("single_c2_fwd1", 32'(fwd_data1), 32'(exp_fwd));
    next_cycle();
    mid_cycle();
    chk("single_c3_we", 32'(WriteReg), 32'd1);
    chk("single_c3_dstreg", 32'(DstReg), 32'd5);
    chk("single_c3_dstdata", 32'(DstData), 32'h1234);
    chk("single_c3_pend1", 32'(pend1), 32'd1);
    next_cycle();
    mid_cycle();
    chk("single_c4_we", 32'(WriteReg), 32'd0);
    chk("single_c4_pend1", 32'(pend1), 32'd0);
    chk("single_c4_dstreg_hold", 32'(DstReg), 32'd5);

    // Fill with wr_hold, then backpressure
    next_cycle();
    wr_hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      wb_valid = 1'b1; wb_reg = 4'(i); wb_data = 16'(i);
      mid_cycle();
      chk("fill_ready", 32'(wb_ready), 32'd1);
      next_cycle();
    end
    SrcReg1 = 4'd9; wb_reg = 4'd9; wb_data = 16'h0005;
    mid_cycle();
    chk("full_ready", 32'(wb_ready), 32'd0);
    chk("full_we", 32'(WriteReg), 32'd0);
    next_cycle();
    wb_valid = 1'b0; wr_hold = 1'b0;
    mid_cycle();
    chk("full_pend9", 32'(pend1), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      next_cycle();
      mid_cycle();
      chk("drain_we", 32'(WriteReg), 32'd1);
      chk("drain_dstreg", 32'(DstReg), 32'(i));
      chk("drain_dstdata", 32'(DstData), 32'(i));
    end
    next_cycle();
    mid_cycle();
    chk("drain_done_we", 32'(WriteReg), 32'd0);

    // Newest-wins on R7
    next_cycle();
    wr_hold = 1'b1; SrcReg1 = 4'd7; SrcReg2 = 4'd7;
    wb_valid = 1'b1; wb_reg = 4'd7; wb_data = 16'hAAAA;
    next_cycle();
    wb_data = 16'hBBBB;
    next_cycle();
    wb_valid = 1'b0;
    mid_cycle();
`ifdef REGFILE_WB_BYPASS_EN
    exp_fwd = 16'hBBBB;
`else
    exp_fwd = 16'h0000;
`endif
    chk("newest_pend2", 32'(pend2), 32'd1);
    chk("newest_fwd2", 32'(fwd_data2), 32'(exp_fwd));
    chk("newest_fwd1", 32'(fwd_data1), 32'(exp_fwd));
    next_cycle();
    wr_hold = 1'b0;
    next_cycle();
    mid_cycle();
    chk("newest_wr1_data", 32'(DstData), 32'hAAAA);
    chk("newest_wr1_fwd2", 32'(fwd_data2), 32'(exp_fwd));
    next_cycle();
    mid_cycle();
    chk("newest_wr2_data", 32'(DstData), 32'hBBBB);
    chk("newest_wr2_pend2", 32'(pend2), 32'd1);
    next_cycle();
    mid_cycle();
    chk("newest_after_pend2", 32'(pend2), 32'd0);

    // Streaming push+pop at occupancy 1, wrapping pointers
    SrcReg1 = '0; SrcReg2 = '0;
    for (int k = 0; k < 9; k++) begin
      next_cycle();
      wb_valid = 1'b1; wb_reg = 4'(k + 1); wb_data = 16'(16'h0100 + k);
      mid_cycle();
      chk("stream_ready", 32'(wb_ready), 32'd1);
      if (k >= 2) begin
        chk("stream_we", 32'(WriteReg), 32'd1);
        chk("stream_data", 32'(DstData), 32'(16'h0100 + k - 2));
      end
    end
    for (int k = 9; k < 11; k++) begin
      next_cycle();
      wb_valid = 1'b0;
      mid_cycle();
      chk("stream_tail_we", 32'(WriteReg), 32'd1);
      chk("stream_tail_data", 32'(DstData), 32'(16'h0100 + k - 2));
    end
    next_cycle();
    mid_cycle();
    chk("stream_idle_we", 32'(WriteReg), 32'd0);

    // Reset with three queued entries
    next_cycle();
    wr_hold = 1'b1; SrcReg1 = 4'd2; SrcReg2 = 4'd3;
    for (int i = 2; i <= 4; i++) begin
      wb_valid = 1'b1; wb_reg = 4'(i); wb_data = 16'(16'hC000 + i);
      next_cycle();
    end
    wb_valid = 1'b0;
    mid_cycle();
    chk("prerst_pend1", 32'(pend1), 32'd1);
    next_cycle();
    rst = 1'b1; wr_hold = 1'b0;
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mid_cycle();
      chk("postrst_we", 32'(WriteReg), 32'd0);
      chk("postrst_pend1", 32'(pend1), 32'd0);
      chk("postrst_pend2", 32'(pend2), 32'd0);
      next_cycle();
    end
    mid_cycle();
    chk("postrst_dstdata", 32'(DstData), 32'd0);
    chk("postrst_ready", 32'(wb_ready), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/regfile_wb_queue.md
# regfile_wb_queue

Write-side initiator for the 16x16 register file: accepts writeback requests from the pipeline over a valid/ready handshake, buffers them in order, and drives the register file's single write port (`WriteReg`/`DstReg`/`DstData`) one write per cycle. The register file has no internal forwarding. This block therefore also reports, for the two read addresses, whether a write to that register is still in flight. With bypass compiled in, it supplies the newest in-flight data.

## Interface

Parameters:
- `DEPTH`, 4: queue entries, power of two, at least 2.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `wb_valid`  in  1  writeback request valid.
- `wb_reg`  in  4  destination register.
- `wb_data`  in  16  destination data.
- `wb_ready`  out  1  queue can accept this cycle.
- `wr_hold`  in  1  write port unavailable; no drain this cycle.
- `WriteReg`  out  1  register file write enable (registered).
- `DstReg`  out  4  register file write address (registered).
- `DstData`  out  16  register file write data (registered).
- `SrcReg1`, `SrcReg2`  in  4  read addresses currently presented to the register file.
- `pend1`, `pend2`  out  1  write to `SrcRegN` in flight (combinational).
- `fwd_data1`, `fwd_data2`  out  16  newest in-flight data for `SrcRegN` (combinational).

## Operation

- Storage:
  - circular buffer of `DEPTH` entries {reg, data};
  - read/write pointers of log2(`DEPTH`) bits, wrapping;
  - occupancy count of log2(`DEPTH`)+1 bits.
- Push when `wb_valid && wb_ready`.
  - `wb_ready = (count != DEPTH)`.
  - No pass-through when full, even if a pop occurs in the same cycle.
- Pop when `count != 0 && !wr_hold`.
  - The head is loaded into the output register; `WriteReg` is 1 in the next cycle.
  - When not popping, `WriteReg` is 0 next cycle. `DstReg`/`DstData` hold their last value.
- Simultaneous push and pop: count is unchanged and both pointers advance. Holds at any occupancy, including 1.
- Writes to any register, including R0, are queued and issued unchanged.
- In-flight set: all valid queue entries plus the output register while `WriteReg`=1. The register file does not see that data until the edge that ends the cycle.
- Match:
  - `pendN` = 1 if any in-flight entry has reg == `SrcRegN`.
  - Priority order is output register (oldest), then queue from head to tail (newest).
  - The newest match wins for `fwd_dataN`.
  - A same-cycle incoming `wb_*` is not part of the in-flight set.
- Reset:
  - count, pointers, `WriteReg` = 0;
  - `DstReg` = 0, `DstData` = 0;
  - `wb_ready` = 1, `pend1` = `pend2` = 0, `fwd_data1` = `fwd_data2` = 0.
  - Reset during activity discards all queued writes; none are issued.

## Timing

- Latency: a request accepted in cycle N, with the queue empty and `wr_hold`=0, is popped in N+1. `WriteReg`=1 in N+2, and the register file captures it at the end of N+2.
- Throughput: one push and one pop per cycle sustained.
- `pendN` is first asserted in N+1 and deasserts in the cycle after the register file write edge, unless newer entries still match.
- `wr_hold` only blocks the pop decision. An already-registered write completes.
- `wb_ready` depends only on registered state, with no combinational path from `wb_valid`.

## Configuration

- `REGFILE_WB_BYPASS_EN` defined:
  - `fwd_dataN` carries the newest matching in-flight data;
  - the consumer uses `pendN ? fwd_dataN : SrcDataN`.
- Not defined:
  - `fwd_data1` and `fwd_data2` are tied to 0 and the data-select logic is removed;
  - `pendN` is still produced, and the consumer stalls the read while it is 1.

## Structure

- Shared package:
  - `REG_ADDR_W`=4, `DATA_W`=16;
  - `wbq_entry_t` {reg, data};
  - default `DEPTH`.
- Sub-module `regfile_wb_match`:
  - one instance per read port;
  - inputs are the in-flight entries in age order, their valid bits, and the address;
  - outputs are the hit flag and the newest data.

## Test plan

- Reset then idle:
  - all outputs are at their reset values;
  - `wb_ready`=1.
- Single write:
  - push R5=0x1234 at cycle 1;
  - `WriteReg`=1, `DstReg`=5, `DstData`=0x1234 at cycle 3 only;
  - `pend1`=1 for `SrcReg1`=5 over cycles 2–3, and 0 at cycle 4.
- Fill and backpressure:
  - with `wr_hold`=1, push R1..R4 = 0x0001..0x0004;
  - `wb_ready`=0, and a fifth push is not accepted;
  - release `wr_hold`: writes R1..R4 are issued in order on 4 consecutive cycles.
- Newest-wins bypass (`REGFILE_WB_BYPASS_EN`):
  - with `wr_hold`=1, push R7=0xAAAA then R7=0xBBBB;
  - `SrcReg2`=7 gives `pend2`=1 and `fwd_data2`=0xBBBB.
- Simultaneous push and pop at count=1 with pointer wrap:
  - count stays 1;
  - order is preserved across 2×`DEPTH` transfers.
- Mid-operation reset:
  - assert `rst` with 3 queued entries;
  - no `WriteReg` pulse follows, and `pend1`=`pend2`=0.
